// File: rtl/nn_param_loader.sv
// Byte-stream frame loader: packs a valid/ready byte stream into a shadow register,
// then commits it to a stable parameter bus and holds load_params for LOAD_CYCLES cycles.
module nn_param_loader #(
  parameter int unsigned FRAME_BITS  = 368,
  parameter int unsigned LOAD_CYCLES = 3,
  parameter int unsigned NBYTES      = (FRAME_BITS + 7) / 8,
  parameter int unsigned CNT_W       = $clog2(NBYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_sof,
  output logic                  s_ready,
  output logic [FRAME_BITS-1:0] params,
  output logic                  load_params,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int unsigned LC_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    COMMIT,
    LOAD
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [LC_W-1:0]         lcnt_q;
  logic [FRAME_BITS-1:0]   shadow_q;
  logic [FRAME_BITS-1:0]   shadow_d;
  logic [FRAME_BITS-1:0]   params_q;
  logic                    load_q;
  logic                    done_q;
  logic                    err_q;
  logic [CNT_W-1:0]        wr_idx;
  logic                    beat;

  // rst gates ready so no byte is acknowledged during any reset cycle.
  assign s_ready = !rst && ((state_q == IDLE) || (state_q == FILL));
  assign beat    = s_valid && s_ready;
  assign wr_idx  = s_sof ? '0 : cnt_q;

  // Byte write into the shadow; bits beyond FRAME_BITS in the last byte are dropped.
  always_comb begin
    shadow_d = shadow_q;
    for (int unsigned i = 0; i < FRAME_BITS; i++) begin
      if (wr_idx == CNT_W'(i / 8)) begin
        shadow_d[i] = s_data[3'(i % 8)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lcnt_q   <= '0;
      shadow_q <= '0;
      params_q <= '0;
      load_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (beat) begin
            if (s_sof) begin
              shadow_q <= shadow_d;
              cnt_q    <= CNT_W'(1);
              state_q  <= (NBYTES == 1) ? COMMIT : FILL;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        FILL: begin
          if (beat) begin
            shadow_q <= shadow_d;
            if (s_sof) begin
              err_q   <= 1'b1;
              cnt_q   <= CNT_W'(1);
              state_q <= (NBYTES == 1) ? COMMIT : FILL;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(NBYTES - 1)) begin
                state_q <= COMMIT;
              end
            end
          end
        end
        COMMIT: begin
          params_q <= shadow_q;
          load_q   <= 1'b1;
          done_q   <= 1'b1;
          lcnt_q   <= LC_W'(LOAD_CYCLES - 1);
          state_q  <= LOAD;
        end
        LOAD: begin
          if (lcnt_q == '0) begin
            load_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            lcnt_q <= lcnt_q - LC_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign params      = params_q;
  assign load_params = load_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_nn_param_loader.sv
// Directed bench for nn_param_loader: default 368-bit frame plus a 20-bit, 1-cycle-load instance.
module tb_nn_param_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   s_data, s_data2;
  logic         s_valid, s_valid2;
  logic         s_sof, s_sof2;
  logic         s_ready, s_ready2;
  logic [367:0] params;
  logic [19:0]  params2;
  logic         load_params, load_params2;
  logic         frame_done, frame_done2;
  logic         frame_err, frame_err2;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  nn_param_loader #(.FRAME_BITS(368), .LOAD_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof),
    .s_ready(s_ready), .params(params), .load_params(load_params),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  nn_param_loader #(.FRAME_BITS(20), .LOAD_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .s_data(s_data2), .s_valid(s_valid2), .s_sof(s_sof2),
    .s_ready(s_ready2), .params(params2), .load_params(load_params2),
    .frame_done(frame_done2), .frame_err(frame_err2)
  );

  always @(negedge clk) begin
    if (frame_err === 1'b1) err_cnt++;
    if (frame_done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [367:0] obs, input logic [367:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic sof);
    s_data  = d;
    s_sof   = sof;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic send2(input logic [7:0] d, input logic sof);
    s_data2  = d;
    s_sof2   = sof;
    s_valid2 = 1'b1;
    tick();
    s_valid2 = 1'b0;
    s_sof2   = 1'b0;
  endtask

  // Called 1ns after the edge that accepted the last byte (edge E).
  task automatic expect_commit(input string tag, input logic [367:0] exp);
    check({tag, "_E_load"}, 368'(load_params), 368'(0));
    check({tag, "_E_ready"}, 368'(s_ready), 368'(0));
    tick();
    check({tag, "_E1_params"}, params, exp);
    check({tag, "_E1_load"}, 368'(load_params), 368'(1));
    check({tag, "_E1_done"}, 368'(frame_done), 368'(1));
    tick();
    check({tag, "_E2_load"}, 368'(load_params), 368'(1));
    check({tag, "_E2_done"}, 368'(frame_done), 368'(0));
    check({tag, "_E2_ready"}, 368'(s_ready), 368'(0));
    tick();
    check({tag, "_E3_load"}, 368'(load_params), 368'(1));
    tick();
    check({tag, "_E4_load"}, 368'(load_params), 368'(0));
    check({tag, "_E4_ready"}, 368'(s_ready), 368'(1));
    check({tag, "_E4_params"}, params, exp);
  endtask

  initial begin
    logic [367:0] exp;
    int e0, d0;

    // 1: reset with s_valid held high
    rst = 1'b1; s_valid = 1'b1; s_sof = 1'b1; s_data = 8'h99;
    s_valid2 = 1'b0; s_sof2 = 1'b0; s_data2 = 8'h00;
    tick();
    check("rst_params", params, '0);
    check("rst_load", 368'(load_params), 368'(0));
    check("rst_ready", 368'(s_ready), 368'(0));
    check("rst_done", 368'(frame_done), 368'(0));
    check("rst_err", 368'(frame_err), 368'(0));
    tick();
    check("rst_ready2", 368'(s_ready), 368'(0));
    check("rst_params_b", 368'(params2), 368'(0));
    rst = 1'b0; s_valid = 1'b0; s_sof = 1'b0;
    #1;
    check("post_rst_ready", 368'(s_ready), 368'(1));

    // 2: full back-to-back frame, byte i = i
    d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 46; i++) send(8'(i), i == 0);
    for (int i = 0; i < 46; i++) exp[8*i +: 8] = 8'(i);
    expect_commit("full", exp);
    check("full_done_cnt", 368'(done_cnt - d0), 368'(1));
    check("full_err_cnt", 368'(err_cnt - e0), 368'(0));

    // 3: same frame with idle gaps between beats
    d0 = done_cnt;
    for (int i = 0; i < 46; i++) begin
      send(8'(i), i == 0);
      if (i != 45) tick();
    end
    expect_commit("gaps", exp);
    check("gaps_done_cnt", 368'(done_cnt - d0), 368'(1));

    // 4: early sof after 10 bytes of 0xAA, then 46 bytes of 0x55
    d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 10; i++) send(8'hAA, i == 0);
    for (int i = 0; i < 46; i++) send(8'h55, i == 0);
    for (int i = 0; i < 46; i++) exp[8*i +: 8] = 8'h55;
    expect_commit("early", exp);
    check("early_err_cnt", 368'(err_cnt - e0), 368'(1));
    check("early_done_cnt", 368'(done_cnt - d0), 368'(1));

    // 5: stray byte in IDLE, then a normal frame
    e0 = err_cnt; d0 = done_cnt;
    send(8'h77, 1'b0);
    check("stray_ready", 368'(s_ready), 368'(1));
    check("stray_load", 368'(load_params), 368'(0));
    tick();
    check("stray_err_cnt", 368'(err_cnt - e0), 368'(1));
    check("stray_done_cnt", 368'(done_cnt - d0), 368'(0));
    for (int i = 0; i < 46; i++) send(8'(i) ^ 8'hA5, i == 0);
    for (int i = 0; i < 46; i++) exp[8*i +: 8] = 8'(i) ^ 8'hA5;
    expect_commit("after_stray", exp);
    check("after_stray_err_cnt", 368'(err_cnt - e0), 368'(1));

    // 6: reset mid-fill, then a full 0x3C frame
    e0 = err_cnt;
    for (int i = 0; i < 20; i++) send(8'h11, i == 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_params", params, '0);
    check("midrst_load", 368'(load_params), 368'(0));
    check("midrst_ready", 368'(s_ready), 368'(1));
    for (int i = 0; i < 46; i++) send(8'h3C, i == 0);
    for (int i = 0; i < 46; i++) exp[8*i +: 8] = 8'h3C;
    expect_commit("post_rst", exp);
    check("post_rst_err_cnt", 368'(err_cnt - e0), 368'(0));

    // 20-bit frame: top nibble of the last byte is dropped; 1-cycle load
    check("w20_params0", 368'(params2), 368'(0));
    send2(8'h12, 1'b1);
    send2(8'h34, 1'b0);
    send2(8'hFF, 1'b0);
    check("w20_E_load", 368'(load_params2), 368'(0));
    check("w20_E_ready", 368'(s_ready2), 368'(0));
    tick();
    check("w20_params", 368'(params2), 368'(20'hF3412));
    check("w20_load", 368'(load_params2), 368'(1));
    check("w20_done", 368'(frame_done2), 368'(1));
    tick();
    check("w20_load_off", 368'(load_params2), 368'(0));
    check("w20_done_off", 368'(frame_done2), 368'(0));
    check("w20_ready", 368'(s_ready2), 368'(1));
    check("w20_err", 368'(frame_err2), 368'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
